// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state, select and condition encodings for the multicycle control unit
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH
    } state_t;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC = 2'b01;
    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA = 2'b01;
    localparam logic [1:0] RES_ALU = 2'b10;
    localparam logic [1:0] IMM_8 = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;
    localparam logic [1:0] OP_DP = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR = 2'b10;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/flag inputs and datapath controls between control unit and datapath
interface multicycle_ctrl_if;
    logic [19:0] Instr;
    logic [3:0] ALUFlags;
    logic PCWrite;
    logic MemWrite;
    logic RegWrite;
    logic IRWrite;
    logic AdrSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [3:0] ALUControl;
    modport master (
        input Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
        output ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );
    modport slave (
        output Instr, ALUFlags,
        input PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
        input ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );
endinterface

// File: rtl/mc_cond_unit.sv
// mc_cond_unit: NZCV flags register, condition evaluation and gating of write requests
module mc_cond_unit
    import mc_ctrl_pkg::*;
(
    input logic clk,
    input logic reset,
    input logic [3:0] cond,
    input logic [3:0] alu_flags,
    input logic flag_req,
    input logic hold,
    input logic pc_uncond,
    input logic pc_req,
    input logic reg_req,
    input logic mem_req,
    output logic pc_write,
    output logic reg_write,
    output logic mem_write
);
    logic [3:0] flags;
    logic n, z, c, v, cond_ex, cond_q, gate;
    assign {n, z, c, v} = flags;
    // condition code evaluated against the flags register
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = n == v;
            COND_LT: cond_ex = n != v;
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
    // flags load on a passing flag-setting execute; cond_q keeps the pre-update verdict for writeback
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
            cond_q <= 1'b0;
        end else begin
            cond_q <= cond_ex;
            if (flag_req && cond_ex) flags <= alu_flags;
        end
    end
    assign gate = hold ? cond_q : cond_ex;
    assign pc_write = ~reset & (pc_uncond | (pc_req & gate));
    assign reg_write = ~reset & reg_req & gate;
    assign mem_write = ~reset & mem_req & gate;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main FSM and instruction decode for the multicycle ARM core
module multicycle_ctrl
    import mc_ctrl_pkg::*;
(
    input logic clk,
    input logic reset,
    multicycle_ctrl_if.master bus
);
    state_t state, state_nx, dec_nx;
    logic [3:0] cond, cmd, rd, alu_dec, alu_ctl;
    logic [1:0] op, src_a, src_b, res_src;
    logic [5:0] funct;
    logic s, is_cmp, dp_ok, mem_ok, br_ok, rd15, unused_rn;
    logic irw, pc_uncond, pc_req, reg_req, mem_req, flag_req, hold, adr_src;
    assign cond = bus.Instr[19:16];
    assign op = bus.Instr[15:14];
    assign funct = bus.Instr[13:8];
    assign unused_rn = ^bus.Instr[7:4];
    assign rd = bus.Instr[3:0];
    assign cmd = funct[4:1];
    assign s = funct[0];
    assign rd15 = rd == 4'hf;
    assign is_cmp = cmd == CMD_CMP;
    assign dp_ok = cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_AND || cmd == CMD_ORR || (is_cmp && s);
    assign mem_ok = funct[5:1] == 5'b01100;
    assign br_ok = funct[5:4] == 2'b10;
    assign alu_dec = cmd == CMD_ORR ? ALU_ORR : cmd == CMD_AND ? ALU_AND :
                     (cmd == CMD_SUB || is_cmp) ? ALU_SUB : ALU_ADD;
    assign dec_nx = op == OP_DP ? (dp_ok ? (funct[5] ? EXECUTEI : EXECUTER) : FETCH) :
                    op == OP_MEM ? (mem_ok ? MEMADR : FETCH) :
                    op == OP_BR ? (br_ok ? BRANCH : FETCH) : FETCH;
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else state <= state_nx;
    end
    // next state and Moore control requests
    always_comb begin
        state_nx = FETCH;
        irw = 1'b0;
        pc_uncond = 1'b0;
        pc_req = 1'b0;
        reg_req = 1'b0;
        mem_req = 1'b0;
        flag_req = 1'b0;
        hold = 1'b0;
        adr_src = 1'b0;
        src_a = SRCA_REG;
        src_b = SRCB_REG;
        res_src = RES_ALUOUT;
        alu_ctl = ALU_ADD;
        case (state)
            FETCH: begin
                state_nx = DECODE;
                irw = 1'b1;
                pc_uncond = 1'b1;
                src_a = SRCA_PC;
                src_b = SRCB_FOUR;
                res_src = RES_ALU;
            end
            DECODE: begin
                state_nx = dec_nx;
                src_a = SRCA_PC;
                src_b = SRCB_FOUR;
                res_src = RES_ALU;
            end
            MEMADR: begin
                state_nx = s ? MEMREAD : MEMWRITE;
                src_b = SRCB_IMM;
            end
            MEMREAD: begin
                state_nx = MEMWB;
                adr_src = 1'b1;
            end
            MEMWB: begin
                res_src = RES_DATA;
                reg_req = 1'b1;
                pc_req = rd15;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mem_req = 1'b1;
            end
            EXECUTER, EXECUTEI: begin
                state_nx = ALUWB;
                src_b = state == EXECUTEI ? SRCB_IMM : SRCB_REG;
                alu_ctl = alu_dec;
                flag_req = s;
            end
            ALUWB: begin
                hold = 1'b1;
                reg_req = ~is_cmp;
                pc_req = rd15 & ~is_cmp;
            end
            BRANCH: begin
                src_b = SRCB_IMM;
                res_src = RES_ALU;
                pc_req = 1'b1;
            end
            default: state_nx = FETCH;
        endcase
    end
    mc_cond_unit u_cond (
        .clk(clk),
        .reset(reset),
        .cond(cond),
        .alu_flags(bus.ALUFlags),
        .flag_req(flag_req),
        .hold(hold),
        .pc_uncond(pc_uncond),
        .pc_req(pc_req),
        .reg_req(reg_req),
        .mem_req(mem_req),
        .pc_write(bus.PCWrite),
        .reg_write(bus.RegWrite),
        .mem_write(bus.MemWrite)
    );
    assign bus.IRWrite = ~reset & irw;
    assign bus.AdrSrc = ~reset & adr_src;
    assign bus.RegSrc = reset ? 2'b00 : {op == OP_MEM && !s, op == OP_BR};
    assign bus.ImmSrc = reset ? 2'b00 : op;
    assign bus.ALUSrcA = reset ? 2'b00 : src_a;
    assign bus.ALUSrcB = reset ? 2'b00 : src_b;
    assign bus.ResultSrc = reset ? 2'b00 : res_src;
    assign bus.ALUControl = reset ? 4'b0000 : alu_ctl;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized instruction streams against a per-instruction reference model
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    logic [3:0] m_flags;
    multicycle_ctrl_if bus();
    multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return 32'({bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc, bus.RegSrc,
                    bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.ALUControl});
    endfunction

    function automatic logic [31:0] pk(input bit pcw, input bit mw, input bit rw, input bit irw, input bit adr,
                                       input logic [1:0] srca, input logic [1:0] srcb, input logic [1:0] res,
                                       input logic [3:0] alu, input logic [31:0] ins);
        logic [1:0] op;
        logic [1:0] regsrc;
        op = ins[27:26];
        regsrc = {op == 2'd1 && !ins[20], op == 2'd2};
        return 32'({pcw, mw, rw, irw, adr, regsrc, srca, srcb, res, op, alu});
    endfunction

    // ARM conditions come in complementary pairs: cond[0] inverts the base predicate
    function automatic bit cond_true(input logic [3:0] cd, input logic [3:0] f);
        bit n, z, c, v, base;
        {n, z, c, v} = f;
        case (cd[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = n == v;
            3'd6: base = !z && (n == v);
            default: return cd == 4'he;
        endcase
        return base ^ cd[0];
    endfunction

    task automatic run(input logic [31:0] ins, input logic [3:0] af, input string nm);
        logic [31:0] q[$];
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] cmd, alu;
        bit ce, rd15, cmp, dp_ok;
        op = ins[27:26];
        fn = ins[25:20];
        cmd = fn[4:1];
        cmp = cmd == 4'd10;
        ce = cond_true(ins[31:28], m_flags);
        rd15 = ins[15:12] == 4'hf;
        dp_ok = cmd == 4'd0 || cmd == 4'd2 || cmd == 4'd4 || cmd == 4'd12 || (cmp && fn[0]);
        alu = cmd == 4'd12 ? 4'd3 : cmd == 4'd0 ? 4'd2 : (cmd == 4'd2 || cmp) ? 4'd1 : 4'd0;
        bus.Instr = ins[31:12];
        bus.ALUFlags = af;
        q.push_back(pk(1, 0, 0, 1, 0, 2'd1, 2'd2, 2'd2, 4'd0, ins));
        q.push_back(pk(0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd2, 4'd0, ins));
        if (op == 2'd0 && dp_ok) begin
            q.push_back(pk(0, 0, 0, 0, 0, 2'd0, fn[5] ? 2'd1 : 2'd0, 2'd0, alu, ins));
            q.push_back(pk(ce && rd15 && !cmp, 0, ce && !cmp, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, ins));
        end else if (op == 2'd1 && fn[5:1] == 5'b01100) begin
            q.push_back(pk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 4'd0, ins));
            if (fn[0]) begin
                q.push_back(pk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0, ins));
                q.push_back(pk(ce && rd15, 0, ce, 0, 0, 2'd0, 2'd0, 2'd1, 4'd0, ins));
            end else begin
                q.push_back(pk(0, ce, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0, ins));
            end
        end else if (op == 2'd2 && fn[5:4] == 2'b10) begin
            q.push_back(pk(ce, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 4'd0, ins));
        end
        foreach (q[k]) begin
            #1 check($sformatf("%s.c%0d", nm, k), obs(), q[k]);
            @(negedge clk);
        end
        if (op == 2'd0 && dp_ok && fn[0] && ce) m_flags = af;
        #1 check({nm, ".flags"}, 32'(dut.u_cond.flags), 32'(m_flags));
    endtask

    logic [3:0] cmds[5] = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd10};
    logic [31:0] str_i = 32'hE5812004;
    logic [31:0] ins;

    initial begin
        reset = 1'b1;
        bus.Instr = '0;
        bus.ALUFlags = '0;
        m_flags = 4'b0000;
        @(negedge clk);
        #1 check("rst.out", obs(), 32'd0);
        check("rst.flags", 32'(dut.u_cond.flags), 32'd0);
        repeat (2) @(negedge clk);
        #1 check("rst.hold", obs(), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run(32'hE0812003, 4'b1111, "add");
        run(32'hE3520005, 4'b0100, "cmp_z");
        run(32'h0A000002, 4'b0000, "beq_t");
        run(32'hE3520005, 4'b0000, "cmp_nz");
        run(32'h1A000002, 4'b0100, "bne_t");
        run(32'h0A000002, 4'b0100, "beq_nt");
        run(32'hE5912004, 4'b0000, "ldr");
        run(32'hE5812004, 4'b0000, "str");
        run(32'hE09FF003, 4'b1001, "adds_pc");
        run(32'hF0812003, 4'b0110, "nv");
        run(32'hF0912003, 4'b0110, "nvs");
        run(32'hEC000000, 4'b0000, "op11");
        run(32'hE3520005, 4'b1010, "cmp_nv");
        bus.Instr = str_i[31:12];
        bus.ALUFlags = 4'b0000;
        repeat (3) @(negedge clk);
        #1 check("rst.memw_pre", 32'(bus.MemWrite), 32'd1);
        reset = 1'b1;
        #1 check("rst.memw", 32'(bus.MemWrite), 32'd0);
        check("rst.mid_out", obs(), 32'd0);
        check("rst.mid_flags", 32'(dut.u_cond.flags), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_flags = 4'b0000;
        run(str_i, 4'b0000, "post_rst");
        for (int i = 0; i < 150; i++) begin
            ins = $urandom;
            case ($urandom_range(0, 3))
                0: begin
                    ins[27:26] = 2'b00;
                    ins[24:21] = ($urandom_range(0, 5) == 5) ? 4'($urandom) : cmds[$urandom_range(0, 4)];
                    if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hf;
                end
                1: begin
                    ins[27:26] = 2'b01;
                    if ($urandom_range(0, 3) != 0) ins[25:21] = 5'b01100;
                end
                2: ins[27:25] = 3'b101;
                default: ;
            endcase
            if ($urandom_range(0, 2) == 0) ins[31:28] = 4'he;
            run(ins, 4'($urandom), $sformatf("r%0d", i));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
